// File: rtl/adder16_rr_arbiter.sv
// adder16_rr_arbiter: round-robin arbiter that shares one 16-bit ripple
// adder among NUM_REQ requesters using a three-state sequencer (IDLE/GNT/DONE).
// Optional feature macro: ADDER_OVF_FLAG_EN adds the ovf_o signed-overflow flag.
module adder16_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [16*NUM_REQ-1:0]  a_i,
    input  logic [16*NUM_REQ-1:0]  b_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic                   busy_o,
    output logic [15:0]            res_o,
    output logic [ID_W-1:0]        res_id_o,
    output logic                   res_valid_o
`ifdef ADDER_OVF_FLAG_EN
   ,output logic                   ovf_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            win_vld;
    logic [15:0]     op_a, op_b;
    logic [15:0]     sum;
    logic            carry;

    // Round-robin search: first active request starting at ptr+1, wrapping.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!win_vld && req_i[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    // Shared 16-bit ripple-carry adder, fed only from the operand registers.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            sum[i] = op_a[i] ^ op_b[i] ^ carry;
            carry  = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> GNT on any request, then DONE, then IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = GNT;
            GNT:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

    // Registered datapath and outputs: capture on grant, publish result on GNT->DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_o       <= '0;
            res_valid_o <= 1'b0;
            res_o       <= '0;
            res_id_o    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            id_q        <= '0;
            ptr         <= ID_W'(NUM_REQ - 1);
`ifdef ADDER_OVF_FLAG_EN
            ovf_o       <= 1'b0;
`endif
        end else begin
            gnt_o       <= '0;
            res_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt_o[win] <= 1'b1;
                        op_a       <= a_i[{win, 4'h0} +: 16];
                        op_b       <= b_i[{win, 4'h0} +: 16];
                        id_q       <= win;
                        ptr        <= win;
                    end
                end
                GNT: begin
                    res_o       <= sum;
                    res_id_o    <= id_q;
                    res_valid_o <= 1'b1;
`ifdef ADDER_OVF_FLAG_EN
                    ovf_o       <= (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder16_rr_arbiter.sv
// Self-checking bench for adder16_rr_arbiter: expected results are queued
// when requests are driven and popped when res_valid_o pulses.
// Build with ADDER_OVF_FLAG_EN defined to also check ovf_o.
module tb_adder16_rr_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_i;
    logic [16*NUM_REQ-1:0] a_i;
    logic [16*NUM_REQ-1:0] b_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic                  busy_o;
    logic [15:0]           res_o;
    logic [ID_W-1:0]       res_id_o;
    logic                  res_valid_o;
`ifdef ADDER_OVF_FLAG_EN
    logic                  ovf_o;
`endif

    adder16_rr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .res_o       (res_o),
        .res_id_o    (res_id_o),
        .res_valid_o (res_valid_o)
`ifdef ADDER_OVF_FLAG_EN
       ,.ovf_o       (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     res;
        logic            ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned k, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   s;
        e.id  = ID_W'(k);
        e.res = a + b;
        s     = int'($signed(a)) + int'($signed(b));
        e.ovf = (s > 32767) || (s < -32768);
        return e;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int unsigned k);
        return NUM_REQ'(1) << k;
    endfunction

    // Result monitor: every res_valid_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (res_valid_o) begin
            exp_t e;
            int   sz;
            sz = sb.size();
            check("res_gnt_excl", {31'b0, |gnt_o}, 32'd0);
            check("sb_has_entry", {31'b0, (sz > 0)}, 32'd1);
            if (sz > 0) begin
                e = sb.pop_front();
                check("res_val", res_o, e.res);
                check("res_id", res_id_o, e.id);
`ifdef ADDER_OVF_FLAG_EN
                check("res_ovf", ovf_o, e.ovf);
`endif
            end
        end
    end

    task automatic set_ops(input int unsigned k, input logic [15:0] a, input logic [15:0] b);
        a_i[16*k +: 16] = a;
        b_i[16*k +: 16] = b;
    endtask

    // Single-requester operation, checking grant, result pulse and hold.
    task automatic do_op(input int unsigned k, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e = model(k, a, b);
        set_ops(k, a, b);
        req_i    = '0;
        req_i[k] = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        check("op_gnt", gnt_o, onehot(k));
        check("op_busy_gnt", busy_o, 1);
        check("op_rv_in_gnt", res_valid_o, 0);
        req_i[k] = 1'b0;
        @(negedge clk);
        check("op_rv", res_valid_o, 1);
        check("op_busy_done", busy_o, 1);
        check("op_gnt_done", gnt_o, 0);
        @(negedge clk);
        check("op_rv_idle", res_valid_o, 0);
        check("op_busy_idle", busy_o, 0);
        check("op_res_hold", res_o, e.res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        exp_t        e;

        rst_n = 1'b0;
        req_i = '0;
        a_i   = '0;
        b_i   = '0;

        // Reset state with random activity on the inputs.
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            req_i = NUM_REQ'($urandom);
            a_i   = {$urandom, $urandom};
            b_i   = {$urandom, $urandom};
            #1;
            check("rst_gnt", gnt_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_rv", res_valid_o, 0);
            check("rst_res", res_o, 0);
            check("rst_id", res_id_o, 0);
        end
        @(negedge clk);
        req_i = '0;
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1, 16'h1234, 16'h0FF0);
        do_op(3, 16'hFFFF, 16'h0001);
        do_op(0, 16'h7FFF, 16'h0001);
        do_op(2, 16'h8000, 16'h8000);
        do_op(2, 16'hA5A5, 16'h1111);

        // Fresh pointer, then all four requesting continuously.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int unsigned k = 0; k < NUM_REQ; k++) set_ops(k, 16'(k * 16'h1111 + 1), 16'h0100);
        for (int unsigned i = 0; i < 5; i++) sb.push_back(model(i % NUM_REQ, 16'((i % NUM_REQ) * 16'h1111 + 1), 16'h0100));
        req_i = '1;
        for (int unsigned i = 0; i < 5; i++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (gnt_o == '0 && cnt < 8);
            check("fair_gnt", gnt_o, onehot(i % NUM_REQ));
            check("fair_gap", cnt, (i == 0) ? 1 : 3);
        end
        req_i = '0;
        repeat (3) @(negedge clk);

        // Reset pulse during the GNT cycle of requester 2 drops the operation.
        set_ops(2, 16'h4444, 16'h0004);
        req_i = 4'b0100;
        @(negedge clk);
        check("mid_gnt", gnt_o, 4'b0100);
        #2;
        rst_n = 1'b0;
        req_i = '0;
        #1;
        check("mid_gnt_drop", gnt_o, 0);
        check("mid_busy", busy_o, 0);
        check("mid_rv", res_valid_o, 0);
        check("mid_res", res_o, 0);
        @(negedge clk);
        check("mid_rv_rst", res_valid_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rv_after", res_valid_o, 0);

        // After reset the lowest-index active requester wins first.
        set_ops(1, 16'h0101, 16'h0202);
        set_ops(2, 16'hFF00, 16'h0200);
        sb.push_back(model(1, 16'h0101, 16'h0202));
        sb.push_back(model(2, 16'hFF00, 16'h0200));
        req_i = 4'b0110;
        @(negedge clk);
        check("post_gnt1", gnt_o, 4'b0010);
        req_i[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("post_gnt2", gnt_o, 4'b0100);
        req_i[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("post_idle", busy_o, 0);

        e = model(0, 16'h0000, 16'h0000);
        check("sb_empty", sb.size(), 0);
        check("final_gnt", gnt_o, {NUM_REQ{e.ovf}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
